game_flow_ctrl: RTL and testbench

//  Top-level game sequencer for the snake design. It debounces the start and pause keys and

---
 rtl/snake_pkg.sv | 39 +++
 rtl/key_pulse.sv | 56 +++++
 rtl/game_flow_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game sequencer: state encodings,
// BCD score arithmetic and the speed-mode step period table.
package snake_pkg;

    typedef enum logic [2:0] {
        ST_COVER = 3'd0,
        ST_INIT  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } game_state_e;

    localparam logic [7:0] SCORE_MAX = 8'h99;

    // Two-digit BCD increment that sticks at 99 instead of wrapping.
    function automatic logic [7:0] bcd_inc_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v >= SCORE_MAX) begin
            r = SCORE_MAX;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Frames per move step: the base period halves for each speed level,
    // never dropping below one frame.
    function automatic int speed_period(input int base, input logic [1:0] mode);
        int p;
        p = base >> mode;
        if (p < 1) begin
            p = 1;
        end
        return p;
    endfunction

endpackage

// File: rtl/key_pulse.sv
// Push-button front end: two-flop synchronizer, stability debounce and a
// single-cycle press pulse on the filtered rising edge.
module key_pulse #(
    parameter int DB_CNT = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic press_o
);

    localparam int CW = (DB_CNT < 2) ? 1 : $clog2(DB_CNT + 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          filt_q;
    logic          press_q;
    logic [CW-1:0] stableCnt_q;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed from the filtered level
    // for DB_CNT consecutive cycles; any bounce back restarts the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q      <= 1'b0;
            press_q     <= 1'b0;
            stableCnt_q <= '0;
        end else begin
            press_q <= 1'b0;
            if (sync2_q != filt_q) begin
                if (stableCnt_q == CW'(DB_CNT - 1)) begin
                    filt_q      <= sync2_q;
                    press_q     <= sync2_q;
                    stableCnt_q <= '0;
                end else begin
                    stableCnt_q <= stableCnt_q + CW'(1);
                end
            end else begin
                stableCnt_q <= '0;
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer for the snake design: debounced start/pause keys,
// cover/init/play/pause/over state machine, move-step tick generation from
// frame ticks, and BCD score / hi-score keeping. All outputs are registered.
module game_flow_ctrl
    import snake_pkg::*;
#(
    parameter int DB_CNT      = 250000,
    parameter int INIT_CYCLES = 4,
    parameter int BASE_FRAMES = 16,
    parameter int OVER_HOLD   = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_start,
    input  logic       key_pause,
    input  logic       vsync,
    input  logic [1:0] speed_mode,
    input  logic       dead,
    input  logic       eat,
    output logic       disp_sel,
    output logic       game_rst,
    output logic       step_tick,
    output logic [7:0] score,
    output logic [7:0] hiscore,
    output logic       sfx_eat,
    output logic       sfx_over,
    output logic [2:0] state
);

    localparam int IW = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam int FW = (BASE_FRAMES < 2) ? 1 : $clog2(BASE_FRAMES + 1);
    localparam int HW = (OVER_HOLD < 2)   ? 1 : $clog2(OVER_HOLD + 1);

    game_state_e   state_q;
    logic          dispSel_q;
    logic          gameRst_q;
    logic          stepTick_q;
    logic          sfxEat_q;
    logic          sfxOver_q;
    logic [7:0]    score_q;
    logic [7:0]    hiscore_q;
    logic [1:0]    speed_q;
    logic [IW-1:0] initCnt_q;
    logic [FW-1:0] frameCnt_q;
    logic [HW-1:0] holdCnt_q;
    logic          vsync_q;

    logic          startPulse;
    logic          pausePulse;
    logic          frameTick;
    logic          stepDue;
    logic          holdDone;
    logic [7:0]    scoreInc_d;

    key_pulse #(.DB_CNT(DB_CNT)) uStartKey (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_start),
        .press_o (startPulse)
    );

    key_pulse #(.DB_CNT(DB_CNT)) uPauseKey (
        .clk     (clk),
        .rst     (rst),
        .key_i   (key_pause),
        .press_o (pausePulse)
    );

    // Remember last vsync so its falling edge can be seen without extra delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frameTick  = vsync_q & ~vsync;
    assign stepDue    = int'(frameCnt_q) == (speed_period(BASE_FRAMES, speed_q) - 1);
    assign holdDone   = holdCnt_q == HW'(OVER_HOLD);
    assign scoreInc_d = bcd_inc_sat(score_q);

    // Game state machine; in PLAY a dead hit beats a pause press, which beats an eat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_COVER;
            dispSel_q  <= 1'b0;
            gameRst_q  <= 1'b1;
            stepTick_q <= 1'b0;
            sfxEat_q   <= 1'b0;
            sfxOver_q  <= 1'b0;
            score_q    <= 8'h00;
            hiscore_q  <= 8'h00;
            speed_q    <= 2'b00;
            initCnt_q  <= '0;
            frameCnt_q <= '0;
            holdCnt_q  <= '0;
        end else begin
            stepTick_q <= 1'b0;
            sfxEat_q   <= 1'b0;
            sfxOver_q  <= 1'b0;
            case (state_q)
                ST_COVER: begin
                    dispSel_q <= 1'b0;
                    gameRst_q <= 1'b1;
                    if (startPulse) begin
                        state_q   <= ST_INIT;
                        dispSel_q <= 1'b1;
                        initCnt_q <= '0;
                        score_q   <= 8'h00;
                    end
                end
                ST_INIT: begin
                    score_q <= 8'h00;
                    speed_q <= speed_mode;
                    if (initCnt_q == IW'(INIT_CYCLES - 1)) begin
                        state_q    <= ST_PLAY;
                        gameRst_q  <= 1'b0;
                        frameCnt_q <= '0;
                        initCnt_q  <= '0;
                    end else begin
                        initCnt_q <= initCnt_q + IW'(1);
                    end
                end
                ST_PLAY: begin
                    if (dead) begin
                        state_q   <= ST_OVER;
                        sfxOver_q <= 1'b1;
                        holdCnt_q <= '0;
                        if (score_q > hiscore_q) begin
                            hiscore_q <= score_q;
                        end
                    end else if (pausePulse) begin
                        state_q <= ST_PAUSE;
                    end else begin
                        if (eat) begin
                            score_q  <= scoreInc_d;
                            sfxEat_q <= 1'b1;
                        end
                        if (frameTick) begin
                            if (stepDue) begin
                                stepTick_q <= 1'b1;
                                frameCnt_q <= '0;
                            end else begin
                                frameCnt_q <= frameCnt_q + FW'(1);
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pausePulse) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (frameTick && !holdDone) begin
                        holdCnt_q <= holdCnt_q + HW'(1);
                    end
                    if (startPulse && holdDone) begin
                        state_q   <= ST_INIT;
                        gameRst_q <= 1'b1;
                        initCnt_q <= '0;
                        score_q   <= 8'h00;
                    end
                end
                default: begin
                    state_q   <= ST_COVER;
                    dispSel_q <= 1'b0;
                    gameRst_q <= 1'b1;
                end
            endcase
        end
    end

    assign disp_sel  = dispSel_q;
    assign game_rst  = gameRst_q;
    assign step_tick = stepTick_q;
    assign score     = score_q;
    assign hiscore   = hiscore_q;
    assign sfx_eat   = sfxEat_q;
    assign sfx_over  = sfxOver_q;
    assign state     = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl with short debounce, short over-hold and
// a fast vsync model driven one frame at a time by the stimulus sequence.
module tb_game_flow_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       keyStart;
    logic       keyPause;
    logic       vsync;
    logic [1:0] speedMode;
    logic       dead;
    logic       eat;
    logic       dispSel;
    logic       gameRst;
    logic       stepTick;
    logic [7:0] score;
    logic [7:0] hiscore;
    logic       sfxEat;
    logic       sfxOver;
    logic [2:0] state;

    int testsRun    = 0;
    int testsFailed = 0;
    int frameNum    = 0;
    int stepCount   = 0;
    int lastStepFrame = 0;
    int eatSfxCount = 0;
    int initSeen;
    logic [7:0] scoreAtInit;

    localparam logic [2:0] S_COVER = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_PAUSE = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .DB_CNT      (8),
        .INIT_CYCLES (4),
        .BASE_FRAMES (16),
        .OVER_HOLD   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_start  (keyStart),
        .key_pause  (keyPause),
        .vsync      (vsync),
        .speed_mode (speedMode),
        .dead       (dead),
        .eat        (eat),
        .disp_sel   (dispSel),
        .game_rst   (gameRst),
        .step_tick  (stepTick),
        .score      (score),
        .hiscore    (hiscore),
        .sfx_eat    (sfxEat),
        .sfx_over   (sfxOver),
        .state      (state)
    );

    // Count output pulses away from the active edge.
    always @(negedge clk) begin
        if (stepTick) begin
            stepCount     <= stepCount + 1;
            lastStepFrame <= frameNum;
        end
        if (sfxEat) begin
            eatSfxCount <= eatSfxCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle pulse on eat and/or dead, sampled right after the edge that consumes it.
    task automatic applyStimulus(input logic eatVal, input logic deadVal);
        eat  = eatVal;
        dead = deadVal;
        tick(1);
        eat  = 1'b0;
        dead = 1'b0;
    endtask

    // One video frame: vsync low for 2 cycles, high for 6.
    task automatic applyFrame();
        frameNum = frameNum + 1;
        vsync = 1'b0;
        tick(2);
        vsync = 1'b1;
        tick(6);
    endtask

    // Hold a key, release it, and watch for INIT along the way.
    task automatic pressKey(input bit isStart, input int holdCycles, input int releaseCycles,
                            output int seen, output logic [7:0] firstScore);
        seen = 0;
        firstScore = 8'hxx;
        if (isStart) keyStart = 1'b1; else keyPause = 1'b1;
        for (int i = 0; i < holdCycles + releaseCycles; i++) begin
            if (i == holdCycles) begin
                keyStart = 1'b0;
                keyPause = 1'b0;
            end
            tick(1);
            if (state == S_INIT) begin
                if (seen == 0) firstScore = score;
                seen++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; keyStart = 1'b0; keyPause = 1'b0; vsync = 1'b1;
        speedMode = 2'b10; dead = 1'b0; eat = 1'b0;
        tick(3);
        checkOutput("rst_state", 32'(state), 32'(S_COVER));
        checkOutput("rst_disp_sel", 32'(dispSel), 32'd0);
        checkOutput("rst_game_rst", 32'(gameRst), 32'd1);
        checkOutput("rst_score", 32'(score), 32'h00);
        checkOutput("rst_hiscore", 32'(hiscore), 32'h00);
        checkOutput("rst_step_tick", 32'(stepTick), 32'd0);
        rst = 1'b0;
        tick(2);

        // Bouncing start key never stays stable long enough.
        for (int i = 0; i < 4; i++) begin
            keyStart = 1'b1; tick(3);
            keyStart = 1'b0; tick(3);
        end
        tick(12);
        checkOutput("bounce_no_start", 32'(state), 32'(S_COVER));

        pressKey(1'b1, 20, 20, initSeen, scoreAtInit);
        checkOutput("init_cycles", 32'(initSeen), 32'd4);
        checkOutput("play_state", 32'(state), 32'(S_PLAY));
        checkOutput("play_game_rst", 32'(gameRst), 32'd0);
        checkOutput("play_disp_sel", 32'(dispSel), 32'd1);

        // Speed 10 latched in INIT gives a 4-frame period even after the input changes.
        speedMode = 2'b00;
        frameNum = 0; stepCount = 0;
        for (int f = 1; f <= 8; f++) begin
            applyFrame();
            if (f == 3) checkOutput("step_before_4th", 32'(stepCount), 32'd0);
            if (f == 4) checkOutput("step_at_4th", 32'(stepCount), 32'd1);
        end
        checkOutput("step_count_8", 32'(stepCount), 32'd2);
        checkOutput("last_step_frame", 32'(lastStepFrame), 32'd8);

        eatSfxCount = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, 1'b0);
            tick(1);
        end
        checkOutput("score_12", 32'(score), 32'h12);
        checkOutput("sfx_eat_12", 32'(eatSfxCount), 32'd12);

        pressKey(1'b1, 16, 16, initSeen, scoreAtInit);
        checkOutput("start_in_play_ignored", 32'(state), 32'(S_PLAY));
        checkOutput("start_in_play_no_init", 32'(initSeen), 32'd0);

        // Pause two frames into a 4-frame period; resume keeps the count.
        frameNum = 0; stepCount = 0;
        applyFrame(); applyFrame();
        checkOutput("pre_pause_steps", 32'(stepCount), 32'd0);
        pressKey(1'b0, 16, 16, initSeen, scoreAtInit);
        checkOutput("pause_state", 32'(state), 32'(S_PAUSE));
        applyStimulus(1'b1, 1'b0); tick(1);
        checkOutput("pause_eat_ignored", 32'(score), 32'h12);
        applyStimulus(1'b0, 1'b1); tick(1);
        checkOutput("pause_dead_ignored", 32'(state), 32'(S_PAUSE));
        for (int f = 0; f < 10; f++) applyFrame();
        checkOutput("pause_no_steps", 32'(stepCount), 32'd0);
        pressKey(1'b0, 16, 16, initSeen, scoreAtInit);
        checkOutput("resume_state", 32'(state), 32'(S_PLAY));
        applyFrame();
        checkOutput("resume_frame1", 32'(stepCount), 32'd0);
        applyFrame();
        checkOutput("resume_frame2", 32'(stepCount), 32'd1);

        for (int i = 0; i < 87; i++) begin
            applyStimulus(1'b1, 1'b0);
            tick(1);
        end
        checkOutput("score_99", 32'(score), 32'h99);
        applyStimulus(1'b1, 1'b0); tick(1);
        checkOutput("score_sat", 32'(score), 32'h99);

        applyStimulus(1'b1, 1'b1);
        checkOutput("dead_state", 32'(state), 32'(S_OVER));
        checkOutput("dead_sfx_over", 32'(sfxOver), 32'd1);
        checkOutput("dead_score", 32'(score), 32'h99);
        checkOutput("dead_hiscore", 32'(hiscore), 32'h99);
        tick(1);
        checkOutput("sfx_over_one_cycle", 32'(sfxOver), 32'd0);

        // Over hold of 4 frames: start is refused until the 4th frame has passed.
        frameNum = 0;
        applyFrame(); applyFrame();
        pressKey(1'b1, 16, 16, initSeen, scoreAtInit);
        checkOutput("over_start_f2", 32'(state), 32'(S_OVER));
        pressKey(1'b0, 16, 16, initSeen, scoreAtInit);
        checkOutput("over_pause_ignored", 32'(state), 32'(S_OVER));
        applyFrame();
        pressKey(1'b1, 16, 16, initSeen, scoreAtInit);
        checkOutput("over_start_f3", 32'(state), 32'(S_OVER));
        applyFrame();
        pressKey(1'b1, 20, 20, initSeen, scoreAtInit);
        checkOutput("restart_init_cycles", 32'(initSeen), 32'd4);
        checkOutput("restart_score", 32'(scoreAtInit), 32'h00);
        checkOutput("restart_hiscore", 32'(hiscore), 32'h99);
        checkOutput("restart_play", 32'(state), 32'(S_PLAY));

        applyStimulus(1'b1, 1'b0); tick(1);
        applyStimulus(1'b1, 1'b0); tick(1);
        checkOutput("game2_score", 32'(score), 32'h02);

        // Reset in the middle of a game.
        rst = 1'b1;
        tick(1);
        checkOutput("midrst_state", 32'(state), 32'(S_COVER));
        checkOutput("midrst_disp_sel", 32'(dispSel), 32'd0);
        checkOutput("midrst_game_rst", 32'(gameRst), 32'd1);
        checkOutput("midrst_score", 32'(score), 32'h00);
        tick(2);
        rst = 1'b0;
        tick(2);
        checkOutput("post_rst_state", 32'(state), 32'(S_COVER));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
